// File: rtl/ps2_tx_fifo_if.sv
// Byte-write and status bundle between the key-scan encoder and the PS/2 transmitter.
interface ps2_tx_fifo_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic [LW-1:0] level;
    logic          busy;
    logic          sent;
    logic          aborted;
    logic          dropped;
    logic          host_rts;

    modport master (
        output wr_en, wr_data,
        input  full, level, busy, sent, aborted, dropped, host_rts
    );

    modport slave (
        input  wr_en, wr_data,
        output full, level, busy, sent, aborted, dropped, host_rts
    );
endinterface

// File: rtl/ps2_tx_fifo.sv
// PS/2 device-side transmitter: byte FIFO, quarter-bit tick generator, bus-idle
// qualification, host request-to-send detection and bounded retry after inhibit.
module ps2_tx_fifo #(
    parameter int unsigned CLK_DIV       = 1000,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned IDLE_QUARTERS = 3,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic         clock,
    input  logic         reset,
    ps2_tx_fifo_if.slave bus,
    inout  wire          PS2_CLK,
    inout  wire          PS2_DAT
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IW = (IDLE_QUARTERS > 1) ? $clog2(IDLE_QUARTERS + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUS,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_t;

    state_t        state;
    logic [1:0]    q;
    logic [2:0]    bit_idx;
    logic [IW-1:0] idle_cnt;
    logic [3:0]    retry_cnt;

    logic [TW-1:0] div_cnt;
    logic          tick;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_s;
    logic          dat_s;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_nxt;
    logic          full_q;
    logic          busy_q;
    logic [7:0]    head;

    logic          push;
    logic          pop;
    logic          abort_hit;
    logic          last_try;
    logic          to_idle;

    logic          clk_low;
    logic          dat_low;
    logic          sent_q;
    logic          aborted_q;
    logic          dropped_q;
    logic          host_rts_q;

    // Free-running quarter-bit tick
    assign tick = (div_cnt == TW'(CLK_DIV - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + TW'(1);
        end
    end

    // Two-flop synchronisers; the idle bus reads high through the pull-ups
    always_ff @(posedge clock) begin
        if (!reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
        end
    end

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    assign head      = mem[rd_ptr];
    assign push      = bus.wr_en && !full_q;
    assign last_try  = ((retry_cnt + 4'd1) == 4'(MAX_RETRY));
    assign abort_hit = tick && (q == 2'd3) && !clk_s &&
                       ((state == S_START) || (state == S_DATA) || (state == S_PARITY));
    assign pop       = (tick && (state == S_STOP) && (q == 2'd3)) || (abort_hit && last_try);
    assign to_idle   = tick && (((state == S_GAP) && (q == 2'd3)) ||
                                ((state == S_WAIT_BUS) && (level_q == '0)));

    always_comb begin
        level_nxt = level_q;
        if (push && !pop) begin
            level_nxt = level_q + LW'(1);
        end else if (!push && pop) begin
            level_nxt = level_q - LW'(1);
        end
    end

    // Storage is not reset; only pointers and occupancy are
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level_q <= level_nxt;
            full_q  <= (level_nxt == LW'(DEPTH));
            busy_q  <= (level_nxt != '0) || ((state != S_IDLE) && !to_idle);
        end
    end

    // Frame sequencer; line drive registers are loaded for the phase being entered
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            q          <= '0;
            bit_idx    <= '0;
            idle_cnt   <= '0;
            retry_cnt  <= '0;
            clk_low    <= 1'b0;
            dat_low    <= 1'b0;
            sent_q     <= 1'b0;
            aborted_q  <= 1'b0;
            dropped_q  <= 1'b0;
            host_rts_q <= 1'b0;
        end else begin
            sent_q    <= 1'b0;
            aborted_q <= 1'b0;
            dropped_q <= 1'b0;
            if (tick) begin
                case (state)
                    S_IDLE: begin
                        if (level_q != '0) begin
                            state    <= S_WAIT_BUS;
                            idle_cnt <= '0;
                        end
                    end
                    S_WAIT_BUS: begin
                        if (level_q == '0) begin
                            state      <= S_IDLE;
                            idle_cnt   <= '0;
                            host_rts_q <= 1'b0;
                        end else if (clk_s && dat_s) begin
                            if (IW'(idle_cnt + IW'(1)) == IW'(IDLE_QUARTERS)) begin
                                state      <= S_START;
                                q          <= '0;
                                idle_cnt   <= '0;
                                host_rts_q <= 1'b0;
                                dat_low    <= 1'b1;
                            end else begin
                                idle_cnt <= idle_cnt + IW'(1);
                            end
                        end else begin
                            idle_cnt <= '0;
                            if (clk_s) begin
                                host_rts_q <= 1'b1;
                            end
                        end
                    end
                    S_START, S_DATA, S_PARITY, S_STOP: begin
                        q <= q + 2'd1;
                        if (q == 2'd0) begin
                            clk_low <= 1'b1;
                        end
                        if (q == 2'd2) begin
                            clk_low <= 1'b0;
                        end
                        if (q == 2'd3) begin
                            if (abort_hit) begin
                                state     <= S_WAIT_BUS;
                                q         <= '0;
                                bit_idx   <= '0;
                                idle_cnt  <= '0;
                                clk_low   <= 1'b0;
                                dat_low   <= 1'b0;
                                aborted_q <= 1'b1;
                                if (last_try) begin
                                    dropped_q <= 1'b1;
                                    retry_cnt <= '0;
                                end else begin
                                    retry_cnt <= retry_cnt + 4'd1;
                                end
                            end else begin
                                case (state)
                                    S_START: begin
                                        state   <= S_DATA;
                                        bit_idx <= '0;
                                        dat_low <= ~head[0];
                                    end
                                    S_DATA: begin
                                        if (bit_idx == 3'd7) begin
                                            state   <= S_PARITY;
                                            dat_low <= ^head;
                                        end else begin
                                            bit_idx <= bit_idx + 3'd1;
                                            dat_low <= ~head[3'(bit_idx + 3'd1)];
                                        end
                                    end
                                    S_PARITY: begin
                                        state   <= S_STOP;
                                        dat_low <= 1'b0;
                                    end
                                    default: begin
                                        state     <= S_GAP;
                                        dat_low   <= 1'b0;
                                        sent_q    <= 1'b1;
                                        retry_cnt <= '0;
                                    end
                                endcase
                            end
                        end
                    end
                    S_GAP: begin
                        q <= q + 2'd1;
                        if (q == 2'd3) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

    assign bus.full     = full_q;
    assign bus.level    = level_q;
    assign bus.busy     = busy_q;
    assign bus.sent     = sent_q;
    assign bus.aborted  = aborted_q;
    assign bus.dropped  = dropped_q;
    assign bus.host_rts = host_rts_q;
endmodule

// File: tb/tb_ps2_tx_fifo.sv
// Bench for ps2_tx_fifo: directed pushes, a host model on the open-drain lines,
// and a frame monitor that checks decoded frames against a queue of expected bytes.
module tb_ps2_tx_fifo;
    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned IDLE_Q    = 3;
    localparam int unsigned MAX_RETRY = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic host_clk_low = 1'b0;
    logic host_dat_low = 1'b0;

    wire ps2_clk;
    wire ps2_dat;
    pullup pu_clk (ps2_clk);
    pullup pu_dat (ps2_dat);
    assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = host_dat_low ? 1'b0 : 1'bz;

    ps2_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    ps2_tx_fifo #(
        .CLK_DIV      (CLK_DIV),
        .DEPTH        (DEPTH),
        .IDLE_QUARTERS(IDLE_Q),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .PS2_CLK(ps2_clk),
        .PS2_DAT(ps2_dat)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        bit         drop;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Transmitted order: bit0 start, bits 8:1 data LSB first, bit9 odd parity, bit10 stop
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    // Monitor: decodes DAT at each device-driven CLK fall, checks pulse width and scoreboard
    int         mon_nbits = 0;
    int         n_sent = 0;
    int         n_abort = 0;
    int         n_drop = 0;
    int         n_falls = 0;
    int         low_cnt = 0;
    logic [10:0] mon_bits = '0;
    logic [10:0] last_frame = '0;
    logic       prev_clk = 1'b1;
    logic       pulse_ok = 1'b0;
    exp_t       mon_e;

    always @(negedge clock) begin
        if (!reset) begin
            mon_nbits = 0;
            pulse_ok  = 1'b0;
            prev_clk  = 1'b1;
        end else begin
            if (host_clk_low) begin
                prev_clk = 1'b0;
                pulse_ok = 1'b0;
            end else begin
                if (prev_clk && !ps2_clk) begin
                    if (mon_nbits < 11) mon_bits[mon_nbits] = ps2_dat;
                    mon_nbits++;
                    n_falls++;
                    low_cnt  = 1;
                    pulse_ok = 1'b1;
                end else if (!ps2_clk) begin
                    low_cnt++;
                end else if (!prev_clk && pulse_ok) begin
                    check("clk_low_width", low_cnt, 2 * CLK_DIV);
                    pulse_ok = 1'b0;
                end
                prev_clk = ps2_clk;
            end
            if (bus.aborted) begin
                n_abort++;
                mon_nbits = 0;
                check("dat_released_on_abort", ps2_dat, 1);
            end
            if (bus.sent) begin
                n_sent++;
                last_frame = mon_bits;
                check("frame_bit_count", mon_nbits, 11);
                check("sent_has_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("sent_not_drop", mon_e.drop, 0);
                    check("frame", mon_bits, frame_of(mon_e.data));
                end
                mon_nbits = 0;
            end
            if (bus.dropped) begin
                n_drop++;
                check("drop_has_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("drop_expected", mon_e.drop, 1);
                end
            end
        end
    end

    task automatic push(input logic [7:0] d, input bit enq, input bit drop);
        @(posedge clock);
        #1;
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(posedge clock);
        #1;
        bus.wr_en = 1'b0;
        if (enq) exp_q.push_back('{data: d, drop: drop});
    endtask

    task automatic wait_sent(input int target, input string name);
        int i = 0;
        while (n_sent < target && i < 4000) begin
            @(negedge clock);
            i++;
        end
        check(name, n_sent, target);
    endtask

    task automatic wait_abort(input int target, input string name);
        int i = 0;
        while (n_abort < target && i < 2000) begin
            @(negedge clock);
            i++;
        end
        check(name, n_abort, target);
    endtask

    // Waits until nb bits have been clocked and CLK is released again (start of q3)
    task automatic wait_bits_high(input int nb, input string name);
        int i = 0;
        while (!(mon_nbits == nb && ps2_clk === 1'b1) && i < 2000) begin
            @(negedge clock);
            i++;
        end
        check(name, mon_nbits, nb);
    endtask

    int falls_save;

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;

        reset = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("rst_full", bus.full, 0);
        check("rst_level", bus.level, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_pulses", {bus.sent, bus.aborted, bus.dropped}, 0);
        check("rst_host_rts", bus.host_rts, 0);
        check("rst_lines", {ps2_clk, ps2_dat}, 2'b11);
        reset = 1'b1;

        // Single byte on an idle bus
        push(8'hA5, 1'b1, 1'b0);
        @(negedge clock);
        check("a5_level", bus.level, 1);
        check("a5_busy", bus.busy, 1);
        wait_sent(1, "a5_sent");
        check("a5_frame_literal", last_frame, 11'b11101001010);
        @(negedge clock);
        check("a5_level_after", bus.level, 0);
        repeat (40) @(negedge clock);
        check("a5_idle_busy", bus.busy, 0);
        check("a5_sent_once", n_sent, 1);

        // Fill past full while the host inhibits the bus
        host_clk_low = 1'b1;
        repeat (4) @(negedge clock);
        for (int i = 0; i < 8; i++) push(8'(i), 1'b1, 1'b0);
        @(negedge clock);
        check("fill_full", bus.full, 1);
        check("fill_level", bus.level, 8);
        push(8'h08, 1'b0, 1'b0);
        @(negedge clock);
        check("overflow_level", bus.level, 8);
        check("inhibit_no_send", n_sent, 1);
        host_clk_low = 1'b0;
        wait_sent(9, "fill_drain");
        @(negedge clock);
        check("drain_level", bus.level, 0);
        check("drain_queue", exp_q.size(), 0);

        // Host inhibit at q3 of data bit 3, then resend
        push(8'h1C, 1'b1, 1'b0);
        wait_bits_high(5, "1c_reach_bit3");
        host_clk_low = 1'b1;
        wait_abort(1, "1c_abort");
        @(negedge clock);
        check("1c_level_kept", bus.level, 1);
        check("1c_busy", bus.busy, 1);
        repeat (10) @(negedge clock);
        host_clk_low = 1'b0;
        wait_sent(10, "1c_resent");
        repeat (60) @(negedge clock);
        check("1c_sent_once", n_sent, 10);

        // Every attempt of 0x55 inhibited: dropped on the second abort
        push(8'h55, 1'b1, 1'b1);
        for (int a = 1; a <= 2; a++) begin
            wait_bits_high(1, "55_reach_start_q3");
            host_clk_low = 1'b1;
            wait_abort(1 + a, "55_abort");
            repeat (6) @(negedge clock);
            host_clk_low = 1'b0;
        end
        repeat (4) @(negedge clock);
        check("55_dropped", n_drop, 1);
        check("55_level", bus.level, 0);
        push(8'h66, 1'b1, 1'b0);
        wait_sent(11, "66_sent");
        repeat (40) @(negedge clock);

        // Host request-to-send holds off the frame
        falls_save   = n_falls;
        host_dat_low = 1'b1;
        push(8'h3C, 1'b1, 1'b0);
        repeat (40) @(negedge clock);
        check("rts_set", bus.host_rts, 1);
        check("rts_no_clk", n_falls, falls_save);
        host_dat_low = 1'b0;
        begin
            int i = 0;
            while (bus.host_rts && i < 200) begin
                @(negedge clock);
                i++;
            end
        end
        check("rts_cleared", bus.host_rts, 0);
        check("rts_start_bit", ps2_dat, 0);
        wait_sent(12, "3c_sent");
        repeat (40) @(negedge clock);

        // Reset in the middle of the data bits
        push(8'h81, 1'b0, 1'b0);
        begin
            int i = 0;
            while (mon_nbits != 3 && i < 2000) begin
                @(negedge clock);
                i++;
            end
        end
        check("81_reach_data", mon_nbits, 3);
        check("81_dat_driven", ps2_dat, 0);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_lines", {ps2_clk, ps2_dat}, 2'b11);
        check("midrst_level", bus.level, 0);
        check("midrst_busy", bus.busy, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        falls_save = n_falls;
        repeat (300) @(negedge clock);
        check("postrst_no_frame", n_falls, falls_save);
        check("postrst_no_sent", n_sent, 12);
        check("postrst_busy", bus.busy, 0);
        check("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ps2_tx_fifo.md
Name: ps2_tx_fifo

Overview:
- Parametrised PS/2 device-side transmitter. Sends scan-code bytes to the host: 11-bit frame, open-drain CLK/DAT.
- Successor to the single-byte transmitter. Adds:
  - internal quarter-bit tick generator from the system clock
  - byte FIFO
  - bus-idle qualification and host request-to-send detection
  - bounded automatic retry after host inhibit
- Sits between the key-scan encoder and the PS/2 connector pins.

Parameters:
- CLK_DIV, 1000: system clocks per quarter-bit tick (50 MHz -> 20 us quarter, 12.5 kHz PS/2 clock); must be >= 2.
- DEPTH, 8: FIFO depth in bytes; power of two, >= 2.
- IDLE_QUARTERS, 3: consecutive ticks with both lines high required before a frame starts.
- MAX_RETRY, 3: aborted attempts allowed per byte before the byte is dropped; 1..15.

Ports:
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-low reset
- wr_en  in  1  push wr_data into FIFO
- wr_data  in  8  byte to send
- full  out  1  FIFO holds DEPTH bytes
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- busy  out  1  state != IDLE or level != 0
- sent  out  1  one-cycle pulse: byte transmitted and popped
- aborted  out  1  one-cycle pulse: host inhibited a frame in progress
- dropped  out  1  one-cycle pulse: byte discarded after MAX_RETRY aborts
- host_rts  out  1  host request-to-send seen (synced DAT low while CLK high, bus not driven by us)
- PS2_CLK  inout  1  open-drain clock; drives 0 or z only
- PS2_DAT  inout  1  open-drain data; drives 0 or z only

Behaviour:
- Reset (reset==0 at a clock edge):
  - full=0, level=0, busy=0, sent=aborted=dropped=0, host_rts=0
  - FIFO pointers, retry count and tick counter cleared; state=IDLE
  - both lines z from the following cycle, including mid-frame
- Tick generator:
  - counter 0..CLK_DIV-1; tick=1 for one cycle when counter==CLK_DIV-1, then wraps to 0
  - counter runs freely in all states
- Line sampling: PS2_CLK and PS2_DAT each pass through a 2-flop synchroniser; all decisions use the synced values.
- FIFO:
  - A push when full is ignored and the data is lost; no error flag.
  - A push with a simultaneous pop while full is also ignored (full is judged before the pop).
  - Head is popped only at successful end of STOP, or on drop.
  - level updates the cycle after push/pop; push+pop in the same cycle leaves level unchanged.
- Frame format: start bit 0, 8 data bits LSB first, odd parity (parity bit = ~^data), stop bit 1.
- Bit timing: 4 ticks per bit, phase q=0..3.
  - DAT is driven for the bit at q0 and held through q3.
  - CLK is 0 during q1 and q2, z during q0 and q3.
  - 1-bits are released (z), 0-bits are driven 0.
- State machine (changes only on tick, except reset):
  - IDLE: if level!=0 -> WAIT_BUS, idle count cleared.
  - WAIT_BUS:
    - On each tick, count when synced CLK=1 and DAT=1; otherwise count clears.
    - If CLK=1 and DAT=0, host_rts=1 and the count clears.
    - When the count reaches IDLE_QUARTERS: host_rts=0, go to START.
  - START -> DATA (8 bits, index 0..7) -> PARITY -> STOP -> GAP; each state lasts one bit (4 ticks).
  - GAP: 4 ticks with lines released, then -> IDLE.
- Pop timing: at the last tick of STOP, sent pulses, the head is popped and retry count clears.
- Abort:
  - Checked at the q3 tick of START, DATA and PARITY bits.
  - If synced CLK==0 there, the host inhibited the frame.
  - Lines are released the next cycle and aborted pulses.
  - If retry count+1 == MAX_RETRY: pop the head, pulse dropped, clear retry count.
  - Otherwise increment retry count and keep the head.
  - Next state is WAIT_BUS in both cases.
  - The STOP bit is not abortable.
- host_rts is cleared by reset or on leaving WAIT_BUS. The block never receives host data; a host-to-device receiver consumes host_rts.

Test Plan:
- Push 0xA5 with idle bus, CLK_DIV=4 -> after 3 idle ticks, frame on DAT reads 0,1,0,1,0,0,1,0,1,1,1 (parity 1); 11 CLK low pulses of 2 ticks each; sent pulses once; level returns to 0.
- Push DEPTH+1 bytes 0x00..0x08 while host holds CLK low -> full=1 after 8 pushes, 0x08 ignored; release CLK -> 0x00..0x07 sent in order, each followed by a 4-tick gap.
- Host pulls CLK low at q3 of data bit 3 of 0x1C -> aborted pulses, lines z next cycle; after release, 0x1C is resent in full; sent pulses once.
- MAX_RETRY=2, host aborts every attempt of 0x55 -> aborted pulses twice, dropped on the second abort, level 1->0, next queued byte 0x66 then sent.
- Idle, host drives DAT low with CLK high, one byte queued -> host_rts=1, no CLK pulses; host releases DAT -> after 3 idle ticks, host_rts=0 and the frame starts.
- Assert reset=0 mid-DATA -> next cycle both lines z, level=0, busy=0; after reset=1, no frame occurs without a new push.
